// File: rtl/bram_dwc_pkg.sv
// Shared types and helpers for the wide-to-narrow BRAM width converter.
// Holds the sequencer state encoding and width arithmetic.
package bram_dwc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        RD_CAP  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    function automatic int ratio(input int mst, input int slv);
        return mst / slv;
    endfunction

    function automatic bit isPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/bram_dwc_rd_gather.sv
// Read gather: collects narrow beats into one wide word.
// The output register only changes on the last beat of a read.
module bram_dwc_rd_gather
    import bram_dwc_pkg::*;
#(
    parameter int RATIO         = 4,
    parameter int SLV_DATA_BITW = 32,
    parameter int IDX_BITW      = 2
) (
    input  logic                           Clk_C,
    input  logic                           Rst_R,
    input  logic                           CapEn_S,
    input  logic                           CapLast_S,
    input  logic [IDX_BITW-1:0]            CapIdx_S,
    input  logic [SLV_DATA_BITW-1:0]       SlvRd_D,
    output logic [RATIO*SLV_DATA_BITW-1:0] MstRd_D
);

    logic [RATIO*SLV_DATA_BITW-1:0] stage;
    logic [RATIO*SLV_DATA_BITW-1:0] merged;

    always_comb begin
        merged = stage;
        merged[int'(CapIdx_S)*SLV_DATA_BITW +: SLV_DATA_BITW] = SlvRd_D;
    end

    // Last slice bypasses the stage so the response is ready one cycle sooner.
    always_ff @(posedge Clk_C or posedge Rst_R) begin
        if (Rst_R) begin
            stage   <= '0;
            MstRd_D <= '0;
        end else if (CapEn_S) begin
            stage <= merged;
            if (CapLast_S) begin
                MstRd_D <= merged;
            end
        end
    end

endmodule

// File: rtl/bram_dwc_seq.sv
// Sequencing BRAM width converter: splits each wide access into narrow beats.
// Define BRAM_DWC_SKIP_EN to skip write beats whose byte enables are all zero.
module bram_dwc_seq
    import bram_dwc_pkg::*;
#(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 128,
    parameter int SLV_DATA_BITW = 32
) (
    input  logic                       Clk_C,
    input  logic                       Rst_R,
    input  logic                       MstReq_S,
    output logic                       MstGnt_S,
    input  logic                       MstWe_S,
    input  logic [ADDR_BITW-1:0]       MstAddr_S,
    input  logic [MST_DATA_BITW/8-1:0] MstWrEn_S,
    input  logic [MST_DATA_BITW-1:0]   MstWr_D,
    output logic [MST_DATA_BITW-1:0]   MstRd_D,
    output logic                       MstRdValid_S,
    output logic                       SlvClk_C,
    output logic                       SlvRst_R,
    output logic                       SlvEn_S,
    output logic [ADDR_BITW-1:0]       SlvAddr_S,
    output logic [SLV_DATA_BITW/8-1:0] SlvWrEn_S,
    output logic [SLV_DATA_BITW-1:0]   SlvWr_D,
    input  logic [SLV_DATA_BITW-1:0]   SlvRd_D
);

    localparam int RATIO     = ratio(MST_DATA_BITW, SLV_DATA_BITW);
    localparam int BEAT_BITW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MST_BYTES = MST_DATA_BITW / 8;
    localparam int SLV_BYTES = SLV_DATA_BITW / 8;
    localparam int SLV_OFF   = $clog2(SLV_BYTES);

    localparam logic [BEAT_BITW-1:0] LAST_BEAT =
        BEAT_BITW'(RATIO - 1);
    localparam logic [ADDR_BITW-1:0] WORD_MASK =
        ~ADDR_BITW'(MST_BYTES - 1);

    if (MST_DATA_BITW < SLV_DATA_BITW) begin : gChkWidth
        $error("MST_DATA_BITW must be >= SLV_DATA_BITW");
    end
    if (!isPow2(RATIO) ||
        (MST_DATA_BITW % SLV_DATA_BITW) != 0) begin : gChkRatio
        $error("width ratio must be an integer power of 2");
    end
    if ((SLV_DATA_BITW % 8) != 0 || !isPow2(SLV_BYTES) ||
        !isPow2(MST_BYTES)) begin : gChkBytes
        $error("byte widths must be powers of 2");
    end

    state_t                 state;
    logic [BEAT_BITW-1:0]   beat;
    logic [BEAT_BITW-1:0]   beatNext;
    logic [BEAT_BITW-1:0]   startBeat;
    logic [BEAT_BITW-1:0]   rdIdx;
    logic [ADDR_BITW-1:0]   addrR;
    logic [MST_BYTES-1:0]   wrEnR;
    logic [MST_DATA_BITW-1:0] wrDataR;
    logic                   accept;
    logic                   beatLast;
    logic                   startWr;
    logic                   rdPend;
    logic                   inWrite;

    assign accept  = MstReq_S && (state == IDLE);
    assign inWrite = (state == WRITE);

`ifdef BRAM_DWC_SKIP_EN
    logic                 anyNz;
    logic                 moreNz;
    logic [BEAT_BITW-1:0] firstIdx;
    logic [BEAT_BITW-1:0] nextIdx;

    // Descending scan leaves the lowest qualifying slice in the index.
    always_comb begin
        anyNz    = 1'b0;
        moreNz   = 1'b0;
        firstIdx = '0;
        nextIdx  = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (|MstWrEn_S[i*SLV_BYTES +: SLV_BYTES]) begin
                anyNz    = 1'b1;
                firstIdx = BEAT_BITW'(i);
            end
            if (i > int'(beat) &&
                |wrEnR[i*SLV_BYTES +: SLV_BYTES]) begin
                moreNz  = 1'b1;
                nextIdx = BEAT_BITW'(i);
            end
        end
    end

    assign startWr   = anyNz;
    assign startBeat = firstIdx;
    assign beatLast  = inWrite ? !moreNz : (beat == LAST_BEAT);
    assign beatNext  = inWrite ? nextIdx :
                       (beatLast ? '0 : beat + BEAT_BITW'(1));
`else
    assign startWr   = 1'b1;
    assign startBeat = '0;
    assign beatLast  = (beat == LAST_BEAT);
    assign beatNext  = beatLast ? '0 : beat + BEAT_BITW'(1);
`endif

    always_ff @(posedge Clk_C or posedge Rst_R) begin
        if (Rst_R) begin
            state   <= IDLE;
            beat    <= '0;
            addrR   <= '0;
            wrEnR   <= '0;
            wrDataR <= '0;
            rdPend  <= 1'b0;
            rdIdx   <= '0;
        end else begin
            rdPend <= (state == READ);
            rdIdx  <= beat;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addrR   <= MstAddr_S & WORD_MASK;
                        wrEnR   <= MstWrEn_S;
                        wrDataR <= MstWr_D;
                        if (!MstWe_S) begin
                            state <= READ;
                            beat  <= '0;
                        end else if (startWr) begin
                            state <= WRITE;
                            beat  <= startBeat;
                        end
                    end
                end
                WRITE: begin
                    beat <= beatNext;
                    if (beatLast) state <= IDLE;
                end
                READ: begin
                    beat <= beatNext;
                    if (beatLast) state <= RD_CAP;
                end
                RD_CAP:  state <= RD_RESP;
                RD_RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MstGnt_S     = (state == IDLE);
    assign MstRdValid_S = (state == RD_RESP);
    assign SlvClk_C     = Clk_C;
    assign SlvRst_R     = Rst_R;
    assign SlvEn_S      = inWrite || (state == READ);

    // Beat index sits below the word bits, so no carry can reach them.
    assign SlvAddr_S = SlvEn_S ?
        (addrR | (ADDR_BITW'(beat) << SLV_OFF)) : '0;

    assign SlvWrEn_S = inWrite ?
        wrEnR[int'(beat)*SLV_BYTES +: SLV_BYTES] : '0;

    assign SlvWr_D = inWrite ?
        wrDataR[int'(beat)*SLV_DATA_BITW +: SLV_DATA_BITW] : '0;

    bram_dwc_rd_gather #(
        .RATIO         (RATIO),
        .SLV_DATA_BITW (SLV_DATA_BITW),
        .IDX_BITW      (BEAT_BITW)
    ) uGather (
        .Clk_C     (Clk_C),
        .Rst_R     (Rst_R),
        .CapEn_S   (rdPend),
        .CapLast_S (state == RD_CAP),
        .CapIdx_S  (rdIdx),
        .SlvRd_D   (SlvRd_D),
        .MstRd_D   (MstRd_D)
    );

endmodule
